// File: rtl/pbvi_pkg.sv
// Shared types and constants for the PBVI iteration controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pbvi_pkg;

    localparam int DW      = 16;   // alpha element width
    localparam int NPT_DEF = 16;   // default number of belief points
    localparam int NST_DEF = 2;    // default states per alpha vector

    typedef logic [DW-1:0] word_t;

    // Alpha set at default dimensions, point-major: alpha[p][s].
    typedef word_t [NPT_DEF-1:0][NST_DEF-1:0] alpha_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_CMP    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    function automatic word_t max_word(input word_t a, input word_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pbvi_absdiff.sv
// Unsigned absolute difference |a - b| of two alpha elements.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of inputs.
//   a, b : 16-bit unsigned operands
//   y    : 16-bit unsigned |a - b|, never wraps
module pbvi_absdiff
    import pbvi_pkg::*;
(
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] y
);

    // Subtract the smaller from the larger so the result cannot wrap.
    always_comb begin
        y = (a >= b) ? (a - b) : (b - a);
    end

endmodule

// File: rtl/pbvi_iter_ctrl.sv
// Iteration controller for a PBVI backup pipeline: launch, wait, compare, repeat.
// Latency: en_step 1 cycle after start; CMP takes NPT*NST cycles per iteration.
// Backpressure: waits on en_loop from the pipeline, bounded by a TIMEOUT watchdog.
//   clk/rst            : clock, synchronous active-high reset
//   start, init_alpha  : launch a solve from an initial alpha set (IDLE only)
//   alpha_cur, en_step : alpha set and launch pulse toward the pipeline
//   en_loop, alpha_fb, action_fb : pipeline completion pulse and results
//   policy_action, busy, done, converged, timeout_err, iter_count : status
module pbvi_iter_ctrl
    import pbvi_pkg::*;
#(
    parameter int          NPT      = NPT_DEF,
    parameter int          NST      = NST_DEF,
    parameter int          MAX_ITER = 64,
    parameter logic [15:0] EPS      = 16'h0010,
    parameter int          TIMEOUT  = 1024
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [NPT-1:0][NST-1:0][DW-1:0]  init_alpha,
    output logic [NPT-1:0][NST-1:0][DW-1:0]  alpha_cur,
    output logic                             en_step,
    input  logic                             en_loop,
    input  logic [NPT-1:0][NST-1:0][DW-1:0]  alpha_fb,
    input  logic [NPT-1:0][1:0]              action_fb,
    output logic [NPT-1:0][1:0]              policy_action,
    output logic                             busy,
    output logic                             done,
    output logic                             converged,
    output logic                             timeout_err,
    output logic [7:0]                       iter_count
);

    localparam int NE = NPT * NST;
    localparam int IW = (NE > 1) ? $clog2(NE) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef logic [NPT-1:0][NST-1:0][DW-1:0] alpha_arr_t;
    typedef logic [NE-1:0][DW-1:0]           alpha_flat_t;

    state_t             state_q,     state_d;
    alpha_arr_t         alpha_cur_q, alpha_cur_d;
    alpha_arr_t         alpha_nxt_q, alpha_nxt_d;
    logic [NPT-1:0][1:0] policy_q,   policy_d;
    logic [7:0]         iter_q,      iter_d;
    logic               conv_q,      conv_d;
    logic               to_q,        to_d;
    logic               en_step_q,   en_step_d;
    logic               done_q,      done_d;
    logic [WW-1:0]      wd_q,        wd_d;
    logic [IW-1:0]      idx_q,       idx_d;
    logic [DW-1:0]      max_q,       max_d;

    // Flat point-major views so the CMP index k addresses alpha[k/NST][k%NST]
    // without a divider.
    alpha_flat_t cur_flat;
    alpha_flat_t nxt_flat;
    logic [DW-1:0] diff;
    logic [DW-1:0] max_upd;
    logic          iter_hit;

    assign cur_flat = alpha_cur_q;
    assign nxt_flat = alpha_nxt_q;

    pbvi_absdiff u_absdiff (
        .a (nxt_flat[idx_q]),
        .b (cur_flat[idx_q]),
        .y (diff)
    );

    // Running max including the element being scanned this cycle, so the
    // last-cycle decision sees the complete maximum.
    assign max_upd  = max_word(max_q, diff);
    assign iter_hit = (int'({24'd0, iter_q}) == MAX_ITER);

    always_comb begin
        state_d     = state_q;
        alpha_cur_d = alpha_cur_q;
        alpha_nxt_d = alpha_nxt_q;
        policy_d    = policy_q;
        iter_d      = iter_q;
        conv_d      = conv_q;
        to_d        = to_q;
        en_step_d   = 1'b0;
        done_d      = 1'b0;
        wd_d        = wd_q;
        idx_d       = idx_q;
        max_d       = max_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    alpha_cur_d = init_alpha;
                    iter_d      = 8'd0;
                    conv_d      = 1'b0;
                    to_d        = 1'b0;
                    en_step_d   = 1'b1;
                    state_d     = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                wd_d    = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (en_loop) begin
                    alpha_nxt_d = alpha_fb;
                    policy_d    = action_fb;
                    if (iter_q != 8'hFF) begin
                        iter_d = iter_q + 8'd1;
                    end
                    idx_d   = '0;
                    max_d   = '0;
                    state_d = ST_CMP;
                end else if (wd_q == WW'(TIMEOUT - 1)) begin
                    to_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_CMP: begin
                max_d = max_upd;
                if (idx_q == IW'(NE - 1)) begin
                    alpha_cur_d = alpha_nxt_q;
                    // Convergence wins over the iteration limit.
                    if (max_upd <= EPS) begin
                        conv_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else if (iter_hit) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        en_step_d = 1'b1;
                        state_d   = ST_LAUNCH;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            alpha_cur_q <= '0;
            alpha_nxt_q <= '0;
            policy_q    <= '0;
            iter_q      <= 8'd0;
            conv_q      <= 1'b0;
            to_q        <= 1'b0;
            en_step_q   <= 1'b0;
            done_q      <= 1'b0;
            wd_q        <= '0;
            idx_q       <= '0;
            max_q       <= '0;
        end else begin
            state_q     <= state_d;
            alpha_cur_q <= alpha_cur_d;
            alpha_nxt_q <= alpha_nxt_d;
            policy_q    <= policy_d;
            iter_q      <= iter_d;
            conv_q      <= conv_d;
            to_q        <= to_d;
            en_step_q   <= en_step_d;
            done_q      <= done_d;
            wd_q        <= wd_d;
            idx_q       <= idx_d;
            max_q       <= max_d;
        end
    end

    assign alpha_cur     = alpha_cur_q;
    assign policy_action = policy_q;
    assign iter_count    = iter_q;
    assign converged     = conv_q;
    assign timeout_err   = to_q;
    assign en_step       = en_step_q;
    assign done          = done_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pbvi_iter_ctrl.sv
// Self-checking bench for pbvi_iter_ctrl with a behavioural pipeline stub.
// Latency: n/a.
// Backpressure: n/a.
module tb_pbvi_iter_ctrl;
    import pbvi_pkg::*;

    localparam int NPT  = NPT_DEF;
    localparam int NST  = NST_DEF;
    localparam int NE   = NPT * NST;
    localparam int MAXI = 3;
    localparam int TMO  = 20;

    typedef logic [NPT-1:0][1:0]   act_t;
    typedef logic [NE-1:0][DW-1:0] flat_t;

    typedef struct packed {
        logic       conv;
        logic       to;
        logic [7:0] iter;
        alpha_t     alpha;
        act_t       pol;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    alpha_t     init_alpha;
    alpha_t     alpha_cur;
    logic       en_step;
    logic       en_loop;
    alpha_t     alpha_fb;
    act_t       action_fb;
    act_t       policy_action;
    logic       busy;
    logic       done;
    logic       converged;
    logic       timeout_err;
    logic [7:0] iter_count;

    int   n_checks;
    int   n_errors;
    exp_t sb[$];
    act_t last_pol;

    pbvi_iter_ctrl #(
        .NPT      (NPT),
        .NST      (NST),
        .MAX_ITER (MAXI),
        .EPS      (16'h0010),
        .TIMEOUT  (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .init_alpha    (init_alpha),
        .alpha_cur     (alpha_cur),
        .en_step       (en_step),
        .en_loop       (en_loop),
        .alpha_fb      (alpha_fb),
        .action_fb     (action_fb),
        .policy_action (policy_action),
        .busy          (busy),
        .done          (done),
        .converged     (converged),
        .timeout_err   (timeout_err),
        .iter_count    (iter_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model helpers ----------------
    function automatic alpha_t fill(input word_t v);
        flat_t f;
        for (int k = 0; k < NE; k++) f[k] = v;
        return alpha_t'(f);
    endfunction

    function automatic alpha_t ramp(input word_t base, input word_t step);
        flat_t f;
        for (int k = 0; k < NE; k++) f[k] = base + word_t'(k) * step;
        return alpha_t'(f);
    endfunction

    function automatic alpha_t add_off(input alpha_t a, input flat_t off);
        flat_t f;
        f = flat_t'(a);
        for (int k = 0; k < NE; k++) f[k] = f[k] + off[k];
        return alpha_t'(f);
    endfunction

    function automatic act_t rand_act();
        return act_t'($urandom) | act_t'(1);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input alpha_t init);
        init_alpha = init;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // Pipeline stub: returns fb/act 'delay' cycles after the current cycle.
    task automatic respond(input int delay, input alpha_t fb, input act_t act);
        repeat (delay) tick();
        alpha_fb  = fb;
        action_fb = act;
        en_loop   = 1'b1;
        tick();
        en_loop   = 1'b0;
        last_pol  = act;
    endtask

    task automatic wait_evt(input int budget, output bit got_step, output bit got_done);
        got_step = 1'b0;
        got_done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (en_step === 1'b1) begin got_step = 1'b1; return; end
            if (done === 1'b1)    begin got_done = 1'b1; return; end
            tick();
        end
    endtask

    task automatic wait_done(input int budget, output bit ok, output int cyc, output int steps);
        ok = 1'b0; cyc = 0; steps = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            cyc++;
            if (en_step === 1'b1) steps++;
            if (done === 1'b1) begin ok = 1'b1; return; end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({busy, done, en_step, converged, timeout_err} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_flags: got %b want 00000", {busy, done, en_step, converged, timeout_err});
        end
        n_checks++;
        if (iter_count !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_iter: got %0d want 0", iter_count);
        end
        n_checks++;
        if (alpha_cur !== '0 || policy_action !== '0) begin
            n_errors++;
            $display("FAIL reset_data: alpha %h pol %h want 0", alpha_cur, policy_action);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || en_step !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle: busy %b en_step %b want 0 0", busy, en_step);
        end
    endtask

    task automatic test_single_conv();
        alpha_t init, fb;
        act_t   act;
        bit     ok;
        int     cyc, steps;
        exp_t   e;
        init = fill(16'h1000);
        fb   = fill(16'h1008);
        act  = rand_act();
        sb.push_back('{conv: 1'b1, to: 1'b0, iter: 8'd1, alpha: fb, pol: act});
        do_start(init);
        n_checks++;
        if (en_step !== 1'b1 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL launch_pulse: en_step %b busy %b want 1 1", en_step, busy);
        end
        tick();
        n_checks++;
        if (en_step !== 1'b0) begin
            n_errors++;
            $display("FAIL launch_width: en_step %b want 0", en_step);
        end
        respond(4, fb, act);
        wait_done(NE + 10, ok, cyc, steps);
        n_checks++;
        if (!ok || cyc != NE || steps != 0) begin
            n_errors++;
            $display("FAIL single_cmp_len: done %b after %0d cycles steps %0d want 1 %0d 0", ok, cyc, steps, NE);
        end
        if (sb.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL single_sb: scoreboard empty");
        end else begin
            e = sb.pop_front();
            n_checks++;
            if ({converged, timeout_err, iter_count} !== {e.conv, e.to, e.iter}) begin
                n_errors++;
                $display("FAIL single_status: got c%b t%b i%0d want c%b t%b i%0d",
                         converged, timeout_err, iter_count, e.conv, e.to, e.iter);
            end
            n_checks++;
            if (alpha_cur !== e.alpha || policy_action !== e.pol) begin
                n_errors++;
                $display("FAIL single_data: alpha %h pol %h want %h %h", alpha_cur, policy_action, e.alpha, e.pol);
            end
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL single_done_width: done %b busy %b want 0 0", done, busy);
        end
        repeat (3) tick();
        n_checks++;
        if (alpha_cur !== fb || iter_count !== 8'd1 || converged !== 1'b1) begin
            n_errors++;
            $display("FAIL idle_hold: alpha %h iter %0d conv %b", alpha_cur, iter_count, converged);
        end
    endtask

    task automatic test_max_iter();
        alpha_t init, model, expa;
        flat_t  off;
        act_t   act;
        bit     gs, gd;
        int     steps;
        exp_t   e;
        for (int k = 0; k < NE; k++) off[k] = 16'h0100;
        init = ramp(16'h2000, 16'h0011);
        expa = add_off(add_off(add_off(init, off), off), off);
        sb.push_back('{conv: 1'b0, to: 1'b0, iter: 8'd3, alpha: expa, pol: 'x});
        model = init;
        steps = 0;
        gd    = 1'b0;
        do_start(init);
        for (int it = 0; it < 6; it++) begin
            wait_evt(NE + 20, gs, gd);
            if (gd || !gs) break;
            steps++;
            act = rand_act();
            model = add_off(model, off);
            respond(3, model, act);
        end
        n_checks++;
        if (!gd || steps != MAXI) begin
            n_errors++;
            $display("FAIL maxiter_steps: done %b en_step pulses %0d want 1 %0d", gd, steps, MAXI);
        end
        if (sb.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL maxiter_sb: scoreboard empty");
        end else begin
            e = sb.pop_front();
            e.pol = last_pol;
            n_checks++;
            if ({converged, timeout_err, iter_count} !== {e.conv, e.to, e.iter}) begin
                n_errors++;
                $display("FAIL maxiter_status: got c%b t%b i%0d want c%b t%b i%0d",
                         converged, timeout_err, iter_count, e.conv, e.to, e.iter);
            end
            n_checks++;
            if (alpha_cur !== e.alpha || policy_action !== e.pol) begin
                n_errors++;
                $display("FAIL maxiter_data: alpha %h pol %h want %h %h", alpha_cur, policy_action, e.alpha, e.pol);
            end
        end
        tick();
    endtask

    task automatic test_eps_boundary();
        alpha_t init, fb1;
        flat_t  off;
        act_t   a1, a2;
        bit     ok, gs, gd;
        int     cyc, steps;
        exp_t   e;
        // Run A: +EPS on one element, -EPS on another (reverse direction, no wrap).
        off = '0;
        off[7]  = 16'h0010;
        off[0]  = 16'hFFF0;
        init = ramp(16'h4000, 16'h0040);
        fb1  = add_off(init, off);
        a1   = rand_act();
        sb.push_back('{conv: 1'b1, to: 1'b0, iter: 8'd1, alpha: fb1, pol: a1});
        do_start(init);
        respond(5, fb1, a1);
        wait_done(NE + 10, ok, cyc, steps);
        n_checks++;
        if (!ok || steps != 0) begin
            n_errors++;
            $display("FAIL eps_eq_done: done %b relaunches %0d want 1 0", ok, steps);
        end
        if (sb.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL eps_eq_sb: scoreboard empty");
        end else begin
            e = sb.pop_front();
            n_checks++;
            if ({converged, timeout_err, iter_count} !== {e.conv, e.to, e.iter} || alpha_cur !== e.alpha) begin
                n_errors++;
                $display("FAIL eps_eq_status: got c%b t%b i%0d want c%b t%b i%0d",
                         converged, timeout_err, iter_count, e.conv, e.to, e.iter);
            end
        end
        tick();
        // Run B: EPS+1 on the last scanned element forces another iteration.
        off = '0;
        off[NE-1] = 16'h0011;
        fb1 = add_off(init, off);
        a1  = rand_act();
        a2  = rand_act();
        sb.push_back('{conv: 1'b1, to: 1'b0, iter: 8'd2, alpha: fb1, pol: a2});
        do_start(init);
        respond(5, fb1, a1);
        wait_evt(NE + 20, gs, gd);
        n_checks++;
        if (gs !== 1'b1 || gd !== 1'b0 || converged !== 1'b0) begin
            n_errors++;
            $display("FAIL eps_over_relaunch: step %b done %b conv %b want 1 0 0", gs, gd, converged);
        end
        respond(2, fb1, a2);
        wait_done(NE + 10, ok, cyc, steps);
        if (sb.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL eps_over_sb: scoreboard empty");
        end else begin
            e = sb.pop_front();
            n_checks++;
            if (!ok || {converged, timeout_err, iter_count} !== {e.conv, e.to, e.iter}) begin
                n_errors++;
                $display("FAIL eps_over_status: done %b got c%b t%b i%0d want c%b t%b i%0d",
                         ok, converged, timeout_err, iter_count, e.conv, e.to, e.iter);
            end
            n_checks++;
            if (alpha_cur !== e.alpha || policy_action !== e.pol) begin
                n_errors++;
                $display("FAIL eps_over_data: alpha %h pol %h want %h %h", alpha_cur, policy_action, e.alpha, e.pol);
            end
        end
        tick();
    endtask

    task automatic test_watchdog();
        alpha_t init;
        bit     ok;
        int     cyc, steps;
        exp_t   e;
        init = ramp(16'h0123, 16'h0101);
        sb.push_back('{conv: 1'b0, to: 1'b1, iter: 8'd0, alpha: init, pol: last_pol});
        do_start(init);
        wait_done(TMO + 20, ok, cyc, steps);
        n_checks++;
        if (!ok || cyc != TMO + 1) begin
            n_errors++;
            $display("FAIL wd_latency: done %b after %0d cycles want 1 after %0d", ok, cyc, TMO + 1);
        end
        if (sb.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL wd_sb: scoreboard empty");
        end else begin
            e = sb.pop_front();
            n_checks++;
            if ({converged, timeout_err, iter_count} !== {e.conv, e.to, e.iter}) begin
                n_errors++;
                $display("FAIL wd_status: got c%b t%b i%0d want c%b t%b i%0d",
                         converged, timeout_err, iter_count, e.conv, e.to, e.iter);
            end
            n_checks++;
            if (alpha_cur !== e.alpha || policy_action !== e.pol) begin
                n_errors++;
                $display("FAIL wd_data: alpha %h pol %h want %h %h", alpha_cur, policy_action, e.alpha, e.pol);
            end
        end
        tick();
    endtask

    task automatic test_event_filter();
        alpha_t init, fb;
        flat_t  off;
        act_t   act;
        bit     ok;
        int     cyc, steps;
        exp_t   e;
        for (int k = 0; k < NE; k++) off[k] = 16'h0008;
        init = ramp(16'h3000, 16'h0003);
        fb   = add_off(init, off);
        act  = rand_act();
        sb.push_back('{conv: 1'b1, to: 1'b0, iter: 8'd1, alpha: fb, pol: act});
        do_start(init);
        tick();
        tick();
        init_alpha = fill(16'h7777);   // start during WAIT must be ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (en_step !== 1'b0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL filter_start: en_step %b busy %b want 0 1", en_step, busy);
        end
        respond(2, fb, act);
        repeat (3) tick();
        alpha_fb  = fill(16'hBEEF);    // en_loop during CMP must be ignored
        action_fb = ~act;
        en_loop   = 1'b1;
        tick();
        en_loop   = 1'b0;
        wait_done(NE + 10, ok, cyc, steps);
        n_checks++;
        if (!ok || steps != 0) begin
            n_errors++;
            $display("FAIL filter_steps: done %b extra en_step %0d want 1 0", ok, steps);
        end
        if (sb.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL filter_sb: scoreboard empty");
        end else begin
            e = sb.pop_front();
            n_checks++;
            if ({converged, timeout_err, iter_count} !== {e.conv, e.to, e.iter}) begin
                n_errors++;
                $display("FAIL filter_status: got c%b t%b i%0d want c%b t%b i%0d",
                         converged, timeout_err, iter_count, e.conv, e.to, e.iter);
            end
            n_checks++;
            if (alpha_cur !== e.alpha || policy_action !== e.pol) begin
                n_errors++;
                $display("FAIL filter_data: alpha %h pol %h want %h %h", alpha_cur, policy_action, e.alpha, e.pol);
            end
        end
        tick();
        en_loop = 1'b1;                // en_loop in IDLE
        tick();
        en_loop = 1'b0;
        tick();
        n_checks++;
        if (iter_count !== 8'd1 || busy !== 1'b0 || policy_action !== act) begin
            n_errors++;
            $display("FAIL filter_idle: iter %0d busy %b pol %h want 1 0 %h", iter_count, busy, policy_action, act);
        end
    endtask

    task automatic test_reset_mid_cmp();
        alpha_t init, fb;
        flat_t  off;
        act_t   act;
        bit     ok;
        int     cyc, steps;
        exp_t   e;
        for (int k = 0; k < NE; k++) off[k] = 16'h0040;
        init = ramp(16'h5000, 16'h0007);
        fb   = add_off(init, off);
        do_start(init);
        respond(5, fb, 32'h1357_9BDF);
        repeat (10) tick();            // now at CMP index 10
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({busy, done, en_step, converged, timeout_err} !== 5'b0 || iter_count !== 8'd0) begin
            n_errors++;
            $display("FAIL rstcmp_flags: b%b d%b s%b c%b t%b i%0d want all 0",
                     busy, done, en_step, converged, timeout_err, iter_count);
        end
        n_checks++;
        if (alpha_cur !== '0 || policy_action !== '0) begin
            n_errors++;
            $display("FAIL rstcmp_data: alpha %h pol %h want 0", alpha_cur, policy_action);
        end
        en_loop = 1'b1;
        tick();
        en_loop = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || iter_count !== 8'd0) begin
            n_errors++;
            $display("FAIL rstcmp_late_loop: busy %b iter %0d want 0 0", busy, iter_count);
        end
        // Fresh solve after the abort.
        fb  = add_off(init, '0);
        act = rand_act();
        sb.push_back('{conv: 1'b1, to: 1'b0, iter: 8'd1, alpha: fb, pol: act});
        do_start(init);
        respond(5, fb, act);
        wait_done(NE + 10, ok, cyc, steps);
        if (sb.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL rstcmp_sb: scoreboard empty");
        end else begin
            e = sb.pop_front();
            n_checks++;
            if (!ok || cyc != NE || {converged, timeout_err, iter_count} !== {e.conv, e.to, e.iter}) begin
                n_errors++;
                $display("FAIL rstcmp_rerun: done %b cyc %0d got c%b t%b i%0d want c%b t%b i%0d",
                         ok, cyc, converged, timeout_err, iter_count, e.conv, e.to, e.iter);
            end
            n_checks++;
            if (alpha_cur !== e.alpha || policy_action !== e.pol) begin
                n_errors++;
                $display("FAIL rstcmp_rerun_data: alpha %h pol %h want %h %h", alpha_cur, policy_action, e.alpha, e.pol);
            end
        end
        tick();
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        last_pol   = '0;
        rst        = 1'b1;
        start      = 1'b0;
        en_loop    = 1'b0;
        init_alpha = '0;
        alpha_fb   = '0;
        action_fb  = '0;
        test_reset();
        test_single_conv();
        test_max_iter();
        test_eps_boundary();
        test_watchdog();
        test_event_filter();
        test_reset_mid_cmp();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

endmodule
